// File: rtl/mux4_1_pkg.sv
// Shared definitions for the registered 4:1 multiplexer.
// Provides the lane-select type and its named encodings.
package mux4_1_pkg;

  // Number of data lanes carried on the packed input bus.
  localparam int NUM_LANES = 4;

  // Two-bit lane select.
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'b00;
  localparam sel_t SEL_I1 = 2'b01;
  localparam sel_t SEL_I2 = 2'b10;
  localparam sel_t SEL_I3 = 2'b11;

endpackage : mux4_1_pkg

// File: rtl/mux4_1_sel.sv
// Combinational lane selector for mux4_1.
// Picks lane i_sel out of the packed lane bus; lane k sits at
// i_lanes[k*DATA_W +: DATA_W]. The lane is passed through bit-for-bit.
module mux4_1_sel
  import mux4_1_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [NUM_LANES*DATA_W-1:0] i_lanes,
  input  sel_t                        i_sel,
  output logic [DATA_W-1:0]           o_y
);

  // Decode the select onto one lane slice.
  always_comb begin
    o_y = '0;
    case (i_sel)
      SEL_I0:  o_y = i_lanes[0*DATA_W +: DATA_W];
      SEL_I1:  o_y = i_lanes[1*DATA_W +: DATA_W];
      SEL_I2:  o_y = i_lanes[2*DATA_W +: DATA_W];
      SEL_I3:  o_y = i_lanes[3*DATA_W +: DATA_W];
      default: o_y = '0;
    endcase
  end

endmodule : mux4_1_sel

// File: rtl/mux4_1.sv
// Registered 4:1 multiplexer (top).
// Y is always taken from a flop, so it never follows I or S between edges.
// Build option: define MUX4_1_REG_IN_EN to add an input register stage on
// I and S (latency 2 edges instead of 1). Ports are the same either way.
//
// Interface timing: there is no valid/ready or enable. I and S are sampled
// on every rising clk edge and a fresh pair may be presented every cycle;
// Y reflects the pair sampled 1 edge earlier (2 with the input stage).
// rst_n is asynchronous and active-low and clears every register at once.
module mux4_1
  import mux4_1_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES*DATA_W-1:0] I,
  input  sel_t                        S,
  output logic [DATA_W-1:0]           Y
);

  logic [NUM_LANES*DATA_W-1:0] w_lanes;
  sel_t                        w_sel;
  logic [DATA_W-1:0]           w_y;
  logic [DATA_W-1:0]           r_y;

`ifdef MUX4_1_REG_IN_EN
  logic [NUM_LANES*DATA_W-1:0] r_lanes;
  sel_t                        r_sel;

  // Input stage: capture I and S together so they stay paired through the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lanes <= '0;
      r_sel   <= SEL_I0;
    end else begin
      r_lanes <= I;
      r_sel   <= S;
    end
  end

  assign w_lanes = r_lanes;
  assign w_sel   = r_sel;
`else
  assign w_lanes = I;
  assign w_sel   = S;
`endif

  mux4_1_sel #(
    .DATA_W (DATA_W)
  ) u_sel (
    .i_lanes (w_lanes),
    .i_sel   (w_sel),
    .o_y     (w_y)
  );

  // Output stage: register the selected lane every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
    end else begin
      r_y <= w_y;
    end
  end

  assign Y = r_y;

endmodule : mux4_1

// File: tb/tb_mux4_1.sv
// Self-checking bench for mux4_1: a 1-bit instance and an 8-bit instance
// share clock and reset. Inputs change on the falling edge, outputs are
// checked on the falling edge, so sampling is always half a cycle from
// the active edge. Expected values lag the applied vectors by LAT cycles.
module tb_mux4_1;

`ifdef MUX4_1_REG_IN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  i1;
  logic [1:0]  s1;
  logic        y1;
  logic [31:0] i8;
  logic [1:0]  s8;
  logic [7:0]  y8;

  int n_vec = 0;
  int n_err = 0;

  mux4_1 #(.DATA_W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .I     (i1),
    .S     (s1),
    .Y     (y1)
  );

  mux4_1 #(.DATA_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .I     (i8),
    .S     (s8),
    .Y     (y8)
  );

  // Watchdog: the run is a fixed number of cycles, this only guards a hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    i1 = 4'hF; s1 = 2'b01;
    i8 = 32'hA5A5_A5A5; s8 = 2'b11;
    #1;
    n_vec++; if (y1 !== 1'b0)  begin n_err++; $display("FAIL reset_y1: got %b expected 0", y1); end
    n_vec++; if (y8 !== 8'h00) begin n_err++; $display("FAIL reset_y8: got %h expected 00", y8); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++; if (y1 !== 1'b0)  begin n_err++; $display("FAIL reset_hold_y1: got %b expected 0", y1); end
      n_vec++; if (y8 !== 8'h00) begin n_err++; $display("FAIL reset_hold_y8: got %h expected 00", y8); end
    end
    rst_n = 1'b1;
  endtask

  // I=1010, S stepped 00,01,10,11 -> 0,1,0,1
  task automatic test_select_sweep();
    logic [1:0] sv [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       ev [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_q [$];
    logic       exp;
    i1 = 4'b1010;
    for (int k = 0; k < 4 + LAT; k++) begin
      @(negedge clk);
      if ((k < 4) ? (exp_q.size() == LAT) : (exp_q.size() > 0)) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (y1 !== exp) begin n_err++; $display("FAIL select_sweep step %0d: got %b expected %b", k, y1, exp); end
      end
      if (k < 4) begin
        s1 = sv[k];
        exp_q.push_back(ev[k]);
      end
    end
  endtask

  // S=10 held, I 0000 -> 0100 -> 1011 -> 0,1,0
  task automatic test_data_change();
    logic [3:0] iv [3] = '{4'b0000, 4'b0100, 4'b1011};
    logic       ev [3] = '{1'b0, 1'b1, 1'b0};
    logic       exp_q [$];
    logic       exp;
    s1 = 2'b10;
    for (int k = 0; k < 3 + LAT; k++) begin
      @(negedge clk);
      if ((k < 3) ? (exp_q.size() == LAT) : (exp_q.size() > 0)) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (y1 !== exp) begin n_err++; $display("FAIL data_change step %0d: got %b expected %b", k, y1, exp); end
      end
      if (k < 3) begin
        i1 = iv[k];
        exp_q.push_back(ev[k]);
      end
    end
  endtask

  // 8-bit lanes, S=11,00,10,01 -> DD,AA,CC,BB
  task automatic test_wide_lanes();
    logic [1:0] sv [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
    logic [7:0] ev [4] = '{8'hDD, 8'hAA, 8'hCC, 8'hBB};
    logic [7:0] exp_q [$];
    logic [7:0] exp;
    i8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int k = 0; k < 4 + LAT; k++) begin
      @(negedge clk);
      if ((k < 4) ? (exp_q.size() == LAT) : (exp_q.size() > 0)) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (y8 !== exp) begin n_err++; $display("FAIL wide_lanes step %0d: got %h expected %h", k, y8, exp); end
      end
      if (k < 4) begin
        s8 = sv[k];
        exp_q.push_back(ev[k]);
      end
    end
  endtask

  // I and S changed together every cycle, incl. full-width lane values
  task automatic test_back_to_back();
    logic [31:0] iv [5] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'h80FF_7F01, 32'h0F1E_2D3C};
    logic [1:0]  sv [5] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b10};
    logic [7:0]  ev [5] = '{8'h44, 8'h55, 8'hBB, 8'hFF, 8'h1E};
    logic [7:0]  exp_q [$];
    logic [7:0]  exp;
    for (int k = 0; k < 5 + LAT; k++) begin
      @(negedge clk);
      if ((k < 5) ? (exp_q.size() == LAT) : (exp_q.size() > 0)) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (y8 !== exp) begin n_err++; $display("FAIL back_to_back step %0d: got %h expected %h", k, y8, exp); end
      end
      if (k < 5) begin
        i8 = iv[k];
        s8 = sv[k];
        exp_q.push_back(ev[k]);
      end
    end
  endtask

  // Y must not move between edges when I/S change
  task automatic test_no_comb_path();
    @(negedge clk);
    i1 = 4'b0001; s1 = 2'b00;
    repeat (LAT) @(negedge clk);
    n_vec++; if (y1 !== 1'b1) begin n_err++; $display("FAIL no_comb_settle: got %b expected 1", y1); end
    s1 = 2'b01; i1 = 4'b0100;
    #1;
    n_vec++; if (y1 !== 1'b1) begin n_err++; $display("FAIL no_comb_after_change: got %b expected 1", y1); end
    @(posedge clk); #1;
    n_vec++;
    if (y1 !== ((LAT == 1) ? 1'b0 : 1'b1)) begin
      n_err++; $display("FAIL no_comb_first_edge: got %b expected %b", y1, (LAT == 1) ? 1'b0 : 1'b1);
    end
  endtask

  // Steady Y=1, async reset mid-cycle, hold, release
  task automatic test_reset_mid();
    @(negedge clk);
    i1 = 4'b1111; s1 = 2'b01;
    repeat (LAT + 1) @(negedge clk);
    n_vec++; if (y1 !== 1'b1)  begin n_err++; $display("FAIL rst_mid_steady: got %b expected 1", y1); end
    n_vec++; if (y8 !== 8'h1E) begin n_err++; $display("FAIL rst_mid_steady8: got %h expected 1e", y8); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (y1 !== 1'b0)  begin n_err++; $display("FAIL rst_mid_async_y1: got %b expected 0", y1); end
    n_vec++; if (y8 !== 8'h00) begin n_err++; $display("FAIL rst_mid_async_y8: got %h expected 00", y8); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++; if (y1 !== 1'b0) begin n_err++; $display("FAIL rst_mid_hold: got %b expected 0", y1); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (y1 !== ((LAT == 1) ? 1'b1 : 1'b0)) begin
      n_err++; $display("FAIL rst_release_edge1: got %b expected %b", y1, (LAT == 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    n_vec++; if (y1 !== 1'b1) begin n_err++; $display("FAIL rst_release_edge2: got %b expected 1", y1); end
  endtask

  // 1000 cycles of random I/S against a lane-pick reference
  task automatic test_random();
    logic [7:0]  exp_q [$];
    logic [7:0]  exp;
    logic [31:0] ri;
    logic [1:0]  rs;
    for (int k = 0; k < 1000 + LAT; k++) begin
      @(negedge clk);
      if ((k < 1000) ? (exp_q.size() == LAT) : (exp_q.size() > 0)) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (y8 !== exp) begin n_err++; $display("FAIL random cycle %0d: got %h expected %h", k, y8, exp); end
      end
      if (k < 1000) begin
        ri = $urandom;
        rs = 2'($urandom_range(0, 3));
        i8 = ri;
        s8 = rs;
        exp_q.push_back(ri[rs*8 +: 8]);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_select_sweep();
    test_data_change();
    test_wide_lanes();
    test_back_to_back();
    test_no_comb_path();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mux4_1
